router_demux4: RTL and testbench
================================

# router_demux4

Output-steering stage sitting directly downstream of the 4-way route computation block. It accepts flits from the input channel and latches the 2-bit route code presented with each header flit, routing order 00 self, 01 NS, 10 WE, 11 diagonal. It then forwards the whole packet, header through tail, to the selected output port with valid/ready handshaking, wormhole style. The route stays locked until the tail flit is accepted, so packets are never interleaved on the channel.

## Interface
- DATA_W, default 16: flit width in bits.
- clk_i  in  1: clock; all state updates on rising edge.
- rst_i  in  1: reset; synchronous, active-high.
- route_i  in  2: route code from the route computation block; sampled only on an accepted header flit.
- in_valid_i  in  1: input flit valid.
- in_data_i  in  DATA_W: input flit payload.
- in_last_i  in  1: marks the tail flit; a header with in_last_i=1 is a single-flit packet.
- in_ready_o  out  1: stage can accept a flit this cycle.
- out_valid_o  out  4: per-port valid, one-hot or zero; bit index equals the route code.
- out_data_o  out  DATA_W: flit payload, shared by all ports.
- out_last_o  out  1: tail marker for the flit on out_data_o.
- out_ready_i  in  4: per-port ready from the downstream channels.
- busy_o  out  1: a packet is in progress (state LOCK).
- port_o  out  2: currently locked route code.

## Operation
- Transfer on input: in_valid_i & in_ready_o. Transfer on output port p: out_valid_o[p] & out_ready_i[p].
- FSM with two states:
  - IDLE: the next accepted flit is a header. port_q <= route_i.
    - If in_last_i=0, go to LOCK.
    - If in_last_i=1, stay in IDLE.
  - LOCK: accepted flits carry port_q and route_i is ignored. When a flit with in_last_i=1 is accepted, go to IDLE.
- Each buffered flit carries its own port tag, so a new header accepted in the same cycle a tail drains is legal.
- Output register, one entry (base build): holds data, last and port tag.
  - out_valid_o = valid_q << tag_q.
  - Register loads on input transfer and clears on output transfer without a new input.
- in_ready_o = !valid_q | out_ready_i[tag_q]. This is a combinational path from out_ready_i in the base build.
- Only out_ready_i[tag_q] matters. Ready bits of other ports are ignored.
- busy_o = (state == LOCK). port_o = port_q. port_o holds its last value while in IDLE.
- Flits are delivered in order with no drops and no duplicates. Data and last pass through unmodified.

## Timing
- Reset values:
  - state IDLE, valid_q 0, port_q 00.
  - out_valid_o 0000, out_data_o 0, out_last_o 0.
  - busy_o 0, port_o 00.
  - in_ready_o 1 (base build), 0 in the first cycle after reset (skid build).
- Latency: 1 cycle from input transfer to out_valid_o asserted.
- Full throughput of 1 flit per cycle while the selected port holds ready high.
- Stall: if out_ready_i[tag_q]=0, out_valid_o, out_data_o and out_last_o hold stable until transfer. No retraction of valid.
- Reset mid-packet returns the block to IDLE in the next cycle and discards buffered flits. The upstream block must restart the packet.
- in_valid_i while in_ready_o=0: no effect. Upstream holds the flit.

## Configuration
- Macro ROUTER_DEMUX_SKID_EN.
- Defined: a second entry (skid slot) is added to the output register.
  - in_ready_o = !skid_valid_q. It is a registered output with no combinational path from out_ready_i.
  - When the output register is stalled and an input transfer occurs, the flit goes to the skid slot. The skid slot moves to the output register on the next output transfer.
  - Latency is still 1 cycle and throughput is still 1 flit per cycle. Capacity is 2 flits.
- Undefined: single-entry register with combinational ready, as described in Operation.

## Test plan
- Single flit, route_i=00, data 16'hA5A5, last=1 -> out_valid_o=0001 next cycle with data A5A5 and last=1. busy_o stays 0.
- 4-flit packet, route_i=10 on header, route_i toggles to 01 during the body -> all 4 flits appear on out_valid_o=0100. busy_o=1 from after the header until after the tail, then port_o=10.
- Back-to-back packets: a 2-flit packet to 11, then immediately a 1-flit packet to 01, with all out_ready_i=1 -> flits on consecutive cycles with out_valid_o 1000, 1000, 0010. No bubble.
- Backpressure: out_ready_i[1]=0 for 3 cycles during a packet to 01 -> out_data_o stable and in_ready_o=0 (base build; skid build after 2 flits). No flit lost after ready returns.
- Other-port ready: out_ready_i=1101 while routed to 01 -> the stall persists, because ready on ports 0, 2 and 3 is ignored.
- rst_i pulsed mid-packet, after 2 of 5 flits -> next cycle busy_o=0 and out_valid_o=0000. The next flit is treated as a header and its route_i is honoured.

Source files
------------

// File: rtl/router_demux4.sv
// -----------------------------------------------------------------------------
// router_demux4
//   Output-steering stage behind the 4-way route computation block. The route
//   code on a header flit selects one of four output ports (00 self, 01 NS,
//   10 WE, 11 diagonal). The whole packet follows that port. The route stays
//   locked until the tail flit has been accepted, so packets never interleave.
//
//   Handshake: a flit moves on the input when in_valid_i & in_ready_o, and on
//   output port p when out_valid_o[p] & out_ready_i[p]. Once a valid is
//   raised, it stays high and its payload stays stable until the transfer
//   completes. Only out_ready_i of the port the buffered flit is tagged for
//   is looked at.
//
//   Optional feature (macro ROUTER_DEMUX_SKID_EN):
//     undefined : one output entry. in_ready_o is combinational from
//                 out_ready_i.
//     defined   : adds a skid entry. in_ready_o is registered, and the
//                 capacity is two flits.
//
//   Ports:
//     clk_i, rst_i    clock, synchronous active-high reset
//     route_i         route code, sampled on an accepted header flit
//     in_valid_i      input flit valid
//     in_data_i       input flit payload
//     in_last_i       input tail marker
//     in_ready_o      input ready
//     out_valid_o     per-port valid (one-hot or zero)
//     out_data_o      payload shared by all ports
//     out_last_o      tail marker of the flit on out_data_o
//     out_ready_i     per-port ready from downstream
//     busy_o          packet in progress (FSM state LOCK); state debug output
//     port_o          currently locked route code
// -----------------------------------------------------------------------------
module router_demux4 #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        route_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic [3:0]        out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic [3:0]        out_ready_i,
  output logic              busy_o,
  output logic [1:0]        port_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t            r_state;
  logic [1:0]        r_port;

  // Output entry: every flit carries its own port tag, so a new header may be
  // accepted in the same cycle the previous tail drains.
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [1:0]        r_tag;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [1:0]        w_in_tag;

  assign w_out_xfer = r_valid & out_ready_i[r_tag];
  assign w_in_xfer  = in_valid_i & in_ready_o;
  // Headers take the live route code. Body and tail flits reuse the lock.
  assign w_in_tag   = (r_state == ST_IDLE) ? route_i : r_port;

  // Route lock FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_port  <= 2'b00;
    end else if (w_in_xfer) begin
      case (r_state)
        ST_IDLE: begin
          r_port <= route_i;
          if (!in_last_i) r_state <= ST_LOCK;
        end
        ST_LOCK: begin
          if (in_last_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ROUTER_DEMUX_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_skid_last;
  logic [1:0]        r_skid_tag;
  logic              r_in_ready;
  logic              w_out_open;
  logic              w_skid_valid_nxt;

  // The output entry can take a new flit when it is empty or draining now.
  assign w_out_open = !r_valid | w_out_xfer;

  // in_ready_o is registered as !skid_valid. An input transfer therefore
  // always finds the skid slot empty.
  always_comb begin
    w_skid_valid_nxt = r_skid_valid;
    if (r_skid_valid && w_out_xfer)      w_skid_valid_nxt = 1'b0;
    else if (w_in_xfer && !w_out_open)   w_skid_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_tag        <= 2'b00;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_last  <= 1'b0;
      r_skid_tag   <= 2'b00;
      r_in_ready   <= 1'b0;
    end else begin
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
      if (w_in_xfer && !w_out_open) begin
        r_skid_data <= in_data_i;
        r_skid_last <= in_last_i;
        r_skid_tag  <= w_in_tag;
      end
      if (r_skid_valid && w_out_xfer) begin
        r_data <= r_skid_data;
        r_last <= r_skid_last;
        r_tag  <= r_skid_tag;
      end else if (w_in_xfer && w_out_open) begin
        r_valid <= 1'b1;
        r_data  <= in_data_i;
        r_last  <= in_last_i;
        r_tag   <= w_in_tag;
      end else if (w_out_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign in_ready_o = r_in_ready;
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_tag   <= 2'b00;
    end else if (w_in_xfer) begin
      r_valid <= 1'b1;
      r_data  <= in_data_i;
      r_last  <= in_last_i;
      r_tag   <= w_in_tag;
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
    end
  end

  // Accept when empty or when the current flit leaves this cycle.
  assign in_ready_o = !r_valid | out_ready_i[r_tag];
`endif

  assign out_valid_o = {3'b000, r_valid} << r_tag;
  assign out_data_o  = r_data;
  assign out_last_o  = r_last;
  assign busy_o      = (r_state == ST_LOCK);
  assign port_o      = r_port;

endmodule

// File: tb/tb_router_demux4.sv
// -----------------------------------------------------------------------------
// tb_router_demux4
//   Directed bench for router_demux4 (default build, single output entry).
//   A negedge monitor compares every output transfer against an expected
//   queue filled by the driver. The directed checks cover reset, routing,
//   locking, back-to-back packets, backpressure and mid-packet reset.
// -----------------------------------------------------------------------------
module tb_router_demux4;

  localparam int DATA_W = 16;

  logic              clk;
  logic              rst_i;
  logic [1:0]        route_i;
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_last_i;
  logic              in_ready_o;
  logic [3:0]        out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_last_o;
  logic [3:0]        out_ready_i;
  logic              busy_o;
  logic [1:0]        port_o;

  router_demux4 #(.DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .route_i     (route_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
    .port_o      (port_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // entry = {port[1:0], last, data[15:0]}
  logic [18:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          last_wait;
  logic        m_locked = 1'b0;
  logic [1:0]  m_port   = 2'b00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) idx = 2'(i);
    return idx;
  endfunction

  always @(negedge clk) begin
    logic [18:0] e;
    if (!rst_i && out_valid_o != 4'b0000) begin
      check_eq("out_onehot", 32'($countones(out_valid_o)), 32'd1);
      if ((out_valid_o & out_ready_i) != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_flit", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("flit", 32'({onehot_idx(out_valid_o), out_last_o, out_data_o}), 32'(e));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1. Returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] r, input logic [15:0] d, input logic l);
    logic [1:0] t;
    in_valid_i = 1'b1;
    route_i    = r;
    in_data_i  = d;
    in_last_i  = l;
    last_wait  = 0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (in_ready_o) begin
        t = m_locked ? m_port : r;
        if (!m_locked) m_port = r;
        m_locked = m_locked ? !l : !l;
        exp_q.push_back({t, l, d});
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        return;
      end
      last_wait++;
      @(posedge clk);
    end
    check_eq("send_timeout", 32'd0, 32'd1);
    in_valid_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i       = 1'b1;
    route_i     = 2'b00;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_last_i   = 1'b0;
    out_ready_i = 4'b1111;
    idle_cycles(2);
    rst_i = 1'b0;
    #1;

    // reset state
    check_eq("rst_out_valid", 32'(out_valid_o), 32'h0);
    check_eq("rst_out_data",  32'(out_data_o),  32'h0);
    check_eq("rst_out_last",  32'(out_last_o),  32'h0);
    check_eq("rst_busy",      32'(busy_o),      32'h0);
    check_eq("rst_port",      32'(port_o),      32'h0);
    check_eq("rst_in_ready",  32'(in_ready_o),  32'h1);

    // single-flit packet to self
    send(2'b00, 16'hA5A5, 1'b1);
    check_eq("single_valid", 32'(out_valid_o), 32'h1);
    check_eq("single_data",  32'(out_data_o),  32'hA5A5);
    check_eq("single_last",  32'(out_last_o),  32'h1);
    check_eq("single_busy",  32'(busy_o),      32'h0);
    idle_cycles(1);
    check_eq("single_drained", 32'(out_valid_o), 32'h0);

    // 4-flit packet to WE; route_i changes during the body and must be ignored
    send(2'b10, 16'h1000, 1'b0);
    check_eq("pkt4_busy_hdr",  32'(busy_o),      32'h1);
    check_eq("pkt4_port_hdr",  32'(port_o),      32'h2);
    check_eq("pkt4_valid_hdr", 32'(out_valid_o), 32'h4);
    send(2'b01, 16'h1001, 1'b0);
    check_eq("pkt4_valid_b1",  32'(out_valid_o), 32'h4);
    send(2'b01, 16'h1002, 1'b0);
    check_eq("pkt4_busy_b2",   32'(busy_o),      32'h1);
    send(2'b01, 16'h1003, 1'b1);
    check_eq("pkt4_valid_tl",  32'(out_valid_o), 32'h4);
    check_eq("pkt4_last_tl",   32'(out_last_o),  32'h1);
    check_eq("pkt4_busy_tl",   32'(busy_o),      32'h0);
    check_eq("pkt4_port_tl",   32'(port_o),      32'h2);
    idle_cycles(1);

    // back-to-back: 2 flits to diagonal, then 1 flit to NS, no bubbles
    send(2'b11, 16'h2000, 1'b0);
    check_eq("b2b_v0", 32'(out_valid_o), 32'h8);
    send(2'b00, 16'h2001, 1'b1);
    check_eq("b2b_wait1", 32'(last_wait), 32'd0);
    check_eq("b2b_v1", 32'(out_valid_o), 32'h8);
    send(2'b01, 16'h2002, 1'b1);
    check_eq("b2b_wait2", 32'(last_wait), 32'd0);
    check_eq("b2b_v2", 32'(out_valid_o), 32'h2);
    check_eq("b2b_d2", 32'(out_data_o),  32'h2002);
    check_eq("b2b_port", 32'(port_o),    32'h1);
    idle_cycles(1);

    // backpressure on port 1, with ready held on the other ports
    out_ready_i = 4'b1101;
    send(2'b01, 16'h3000, 1'b0);
    in_valid_i = 1'b1;
    route_i    = 2'b01;
    in_data_i  = 16'h3001;
    in_last_i  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("bp_in_ready", 32'(in_ready_o),  32'h0);
      check_eq("bp_valid",    32'(out_valid_o), 32'h2);
      check_eq("bp_data",     32'(out_data_o),  32'h3000);
      @(posedge clk); #1;
    end
    out_ready_i = 4'b1111;
    send(2'b01, 16'h3001, 1'b0);
    send(2'b10, 16'h3002, 1'b1);
    check_eq("bp_tail_valid", 32'(out_valid_o), 32'h2);
    idle_cycles(2);
    check_eq("bp_drained", 32'(exp_q.size()), 32'd0);

    // reset after 2 of 5 flits
    send(2'b10, 16'h4000, 1'b0);
    send(2'b10, 16'h4001, 1'b0);
    rst_i = 1'b1;
    exp_q.delete();
    m_locked = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check_eq("mrst_busy",  32'(busy_o),      32'h0);
    check_eq("mrst_valid", 32'(out_valid_o), 32'h0);
    send(2'b11, 16'h4100, 1'b1);
    check_eq("mrst_hdr_valid", 32'(out_valid_o), 32'h8);
    check_eq("mrst_hdr_port",  32'(port_o),      32'h3);
    check_eq("mrst_hdr_data",  32'(out_data_o),  32'h4100);
    idle_cycles(3);
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
